// File: rtl/self_purging_adder_nmr_pkg.sv
// self_purging_pkg: shared defaults and helper functions for the self-purging NMR adder.
package self_purging_pkg;
    localparam int DEF_WIDTH = 32;
    localparam int DEF_N_MOD = 5;

    function automatic int cnt_w(input int thresh);
        return $clog2(thresh + 1);
    endfunction

    // Sized for the largest legal module count (7).
    function automatic int popcount(input logic [7:0] m);
        int n;
        n = 0;
        for (int i = 0; i < 8; i++) n += m[i] ? 1 : 0;
        return n;
    endfunction
endpackage

// File: rtl/self_purging_adder_nmr_rc_adder.sv
// rc_adder: parametrised ripple-carry adder producing the full carry-out.
module rc_adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    logic [WIDTH:0] c;
    assign c[0] = cin;
    for (genvar g = 0; g < WIDTH; g++) begin : g_fa
        assign sum[g]   = a[g] ^ b[g] ^ c[g];
        assign c[g+1]   = (a[g] & b[g]) | (c[g] & (a[g] ^ b[g]));
    end
    assign cout = c[WIDTH];
endmodule

// File: rtl/self_purging_adder_nmr.sv
// self_purging_adder_nmr: N-modular redundant adder with bitwise voting and purging of persistently faulty modules.
module self_purging_adder_nmr
    import self_purging_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int N_MOD        = DEF_N_MOD,
    parameter int PURGE_THRESH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             cin,
    input  logic [N_MOD-1:0] fault_en,
    input  logic [WIDTH:0]   fault_pattern,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             out_valid,
    output logic [N_MOD-1:0] alive,
    output logic [N_MOD-1:0] purge_pulse,
    output logic             fail
);
    localparam int CW = cnt_w(PURGE_THRESH);

    logic [WIDTH:0]   mod_out [N_MOD];
    logic [WIDTH:0]   voted;
    logic             tie;
    logic [7:0]       alive_ext;
    int               n_alive;
    int               ones;
    logic [CW-1:0]    cnt      [N_MOD];
    logic [CW-1:0]    cnt_next [N_MOD];
    logic [N_MOD-1:0] purge;

    for (genvar i = 0; i < N_MOD; i++) begin : g_mod
        logic [WIDTH-1:0] s;
        logic             c;
        rc_adder #(.WIDTH(WIDTH)) u_add (
            .a(in1), .b(in2), .cin(cin), .sum(s), .cout(c)
        );
        assign mod_out[i] = {c, s} ^ (fault_en[i] ? fault_pattern : '0);
    end

    // Only alive modules vote; an even split on any bit is a tie and reads 0.
    always_comb begin
        alive_ext = '0;
        alive_ext[N_MOD-1:0] = alive;
        n_alive = popcount(alive_ext);
        voted = '0;
        tie = 1'b0;
        ones = 0;
        for (int b = 0; b <= WIDTH; b++) begin
            ones = 0;
            for (int i = 0; i < N_MOD; i++) ones += (alive[i] && mod_out[i][b]) ? 1 : 0;
            voted[b] = 2 * ones > n_alive;
            tie = tie | (2 * ones == n_alive);
        end
    end

    always_comb begin
        for (int i = 0; i < N_MOD; i++) begin
            cnt_next[i] = cnt[i];
            purge[i] = 1'b0;
            if (in_valid && alive[i]) begin
                cnt_next[i] = (mod_out[i] != voted)
                    ? ((cnt[i] == CW'(PURGE_THRESH)) ? cnt[i] : cnt[i] + 1'b1) : '0;
                purge[i] = cnt_next[i] == CW'(PURGE_THRESH);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum <= '0;
            cout <= 1'b0;
            out_valid <= 1'b0;
            fail <= 1'b0;
            purge_pulse <= '0;
            alive <= '1;
            for (int i = 0; i < N_MOD; i++) cnt[i] <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) {cout, sum} <= voted;
            alive <= alive & ~purge;
            purge_pulse <= purge;
            for (int i = 0; i < N_MOD; i++) cnt[i] <= cnt_next[i];
            fail <= fail | (n_alive == 0) | (in_valid & tie);
        end
    end
endmodule
